// File: rtl/math_div_seq.sv
// Sequential unsigned divider, one restoring quotient bit per cycle, with
// floor / ceil / round-half-up result adjustment and a divide-by-zero flag.
module math_div_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_n,
    input  logic [W-1:0] in_d,
    input  logic [1:0]   in_mode,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_q,
    output logic [W-1:0] out_r,
    output logic         out_dz
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  div_q, div_d;
    logic [1:0]    mode_q, mode_d;
    logic          dz_q, dz_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  q_res_q, q_res_d;
    logic [W-1:0]  r_res_q, r_res_d;
    logic          dz_res_q, dz_res_d;
    logic          in_rdy_q, in_rdy_d;
    logic          out_vld_q, out_vld_d;

    logic [W:0]    rem_sh_s;
    logic          geq_s;
    logic [W-1:0]  diff_s;
    logic          inc_s;

    // Round-half-up test 2*r >= d, carried at W+1 bits so the doubling never truncates.
    function automatic logic round_up(input logic [W-1:0] r, input logic [W-1:0] d);
        return ({r, 1'b0} >= {1'b0, d});
    endfunction

    // Next-state, restoring step and mode adjustment.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        div_d    = div_q;
        mode_d   = mode_q;
        dz_d     = dz_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        q_res_d  = q_res_q;
        r_res_d  = r_res_q;
        dz_res_d = dz_res_q;

        // The remainder is always below d, so the true difference fits in W bits.
        rem_sh_s = {rem_q, dvd_q[W-1]};
        geq_s    = (rem_sh_s >= {1'b0, div_q});
        diff_s   = rem_sh_s[W-1:0] - div_q;

        case (mode_q)
            2'd1:    inc_s = (rem_q != {W{1'b0}});
            2'd2:    inc_s = round_up(rem_q, div_q);
            default: inc_s = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (in_vld) begin
                    dvd_d  = in_n;
                    div_d  = in_d;
                    mode_d = in_mode;
                    dz_d   = (in_d == {W{1'b0}});
                    rem_d  = {W{1'b0}};
                    quo_d  = {W{1'b0}};
                    cnt_d  = CW'(W - 1);
                    if (in_d == {W{1'b0}}) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                dvd_d = {dvd_q[W-2:0], 1'b0};
                if (geq_s) begin
                    rem_d = diff_s;
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh_s[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    state_d = S_BUSY;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    q_res_d  = {W{1'b1}};
                    r_res_d  = dvd_q;
                    dz_res_d = 1'b1;
                end else begin
                    q_res_d  = quo_q + {{(W-1){1'b0}}, inc_s};
                    r_res_d  = rem_q;
                    dz_res_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_rdy_d  = (state_d == S_IDLE);
        out_vld_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            dvd_q     <= {W{1'b0}};
            div_q     <= {W{1'b0}};
            mode_q    <= 2'd0;
            dz_q      <= 1'b0;
            rem_q     <= {W{1'b0}};
            quo_q     <= {W{1'b0}};
            q_res_q   <= {W{1'b0}};
            r_res_q   <= {W{1'b0}};
            dz_res_q  <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            dz_q      <= dz_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            q_res_q   <= q_res_d;
            r_res_q   <= r_res_d;
            dz_res_q  <= dz_res_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign out_q   = q_res_q;
    assign out_r   = r_res_q;
    assign out_dz  = dz_res_q;

endmodule

// File: tb/tb_math_div_seq.sv
// Self-checking bench for math_div_seq (W=8): directed cases, backpressure,
// mid-operation reset and randomized requests against an arithmetic model.
module tb_math_div_seq;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_n;
    logic [7:0] in_d;
    logic [1:0] in_mode;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_q;
    logic [7:0] out_r;
    logic       out_dz;

    int checks = 0;
    int errors = 0;

    math_div_seq #(.W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_n    (in_n),
        .in_d    (in_d),
        .in_mode (in_mode),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_q   (out_q),
        .out_r   (out_r),
        .out_dz  (out_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division followed by the rounding rule.
    task automatic ref_div(input int n, input int d, input int mode,
                           output int q, output int r, output int dz);
        int fq;
        if (d == 0) begin
            q = 255; r = n; dz = 1;
        end else begin
            fq = n / d;
            r  = n % d;
            dz = 0;
            if (mode == 1)      q = fq + ((r != 0) ? 1 : 0);
            else if (mode == 2) q = fq + ((2 * r >= d) ? 1 : 0);
            else                q = fq;
        end
    endtask

    task automatic do_op(input int n, input int d, input int mode, input int bp);
        int eq, er, edz, cyc, exp_lat;
        bit seen;
        ref_div(n, d, mode, eq, er, edz);
        exp_lat = (d == 0) ? 2 : 10;
        chk("pre_in_rdy", 32'(in_rdy), 32'd1);
        in_n = 8'(n); in_d = 8'(d); in_mode = 2'(mode); in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        in_n = 8'($urandom); in_d = 8'($urandom); in_mode = 2'($urandom);
        cyc = 1;
        seen = 1'b0;
        while (cyc <= 20 && !seen) begin
            if (out_vld === 1'b1) begin
                seen = 1'b1;
            end else begin
                chk("busy_in_rdy", 32'(in_rdy), 32'd0);
                @(negedge clk);
                cyc++;
            end
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("done_in_rdy", 32'(in_rdy), 32'd0);
        chk("q", 32'(out_q), 32'(eq));
        chk("r", 32'(out_r), 32'(er));
        chk("dz", 32'(out_dz), 32'(edz));
        for (int i = 0; i < bp; i++) begin
            in_vld = i[0];
            in_n = 8'($urandom); in_d = 8'($urandom);
            @(negedge clk);
            chk("bp_out_vld", 32'(out_vld), 32'd1);
            chk("bp_in_rdy", 32'(in_rdy), 32'd0);
            chk("bp_q", 32'(out_q), 32'(eq));
            chk("bp_r", 32'(out_r), 32'(er));
            chk("bp_dz", 32'(out_dz), 32'(edz));
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        chk("post_out_vld", 32'(out_vld), 32'd0);
        chk("post_in_rdy", 32'(in_rdy), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_n = 8'd0; in_d = 8'd0; in_mode = 2'd0; out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_q", 32'(out_q), 32'd0);
        chk("rst_r", 32'(out_r), 32'd0);
        chk("rst_dz", 32'(out_dz), 32'd0);

        // out_rdy with nothing pending must not produce a result
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_out_vld", 32'(out_vld), 32'd0);
        chk("idle_in_rdy", 32'(in_rdy), 32'd1);
        out_rdy = 1'b0;

        do_op(100, 7, 0, 0);
        do_op(100, 7, 1, 0);
        do_op(98, 7, 1, 0);
        do_op(255, 255, 1, 0);
        do_op(10, 4, 2, 0);
        do_op(9, 4, 2, 0);
        do_op(255, 2, 2, 0);
        do_op(55, 0, 0, 0);
        do_op(55, 0, 2, 1);
        do_op(255, 1, 0, 0);
        do_op(255, 1, 2, 0);
        do_op(0, 255, 1, 0);
        do_op(254, 255, 3, 0);
        do_op(100, 7, 2, 5);

        // Abort a BUSY operation with reset at T+4.
        in_n = 8'd150; in_d = 8'd7; in_mode = 2'd0; in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_vld", 32'(out_vld), 32'd0);
        chk("abort_in_rdy", 32'(in_rdy), 32'd1);
        do_op(200, 9, 1, 0);

        for (int k = 0; k < 40; k++) begin
            int rn, rd;
            rn = $urandom_range(0, 255);
            rd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            do_op(rn, rd, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
